// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS fetch constants and address helpers
package mips_pkg;

  localparam int unsigned BYTE_ADDR_W        = 32;
  localparam int unsigned WORD_ADDR_W        = 30;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int unsigned DEFAULT_IMEM_WORDS = 8192;

  // Byte address to zero-extended word index.
  function automatic logic [BYTE_ADDR_W-1:0] word_index(input logic [BYTE_ADDR_W-1:0] a);
    return {2'b00, a[BYTE_ADDR_W-1:2]};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch unit control, imem and decode-side signal bundle
interface pc_fetch_unit_if;
  import mips_pkg::*;

  logic                   stall;
  logic                   redirect;
  logic [BYTE_ADDR_W-1:0] redirect_pc;
  logic [BYTE_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_instr;
  logic [31:0]            id_instr;
  logic [BYTE_ADDR_W-1:0] id_pc;
  logic [BYTE_ADDR_W-1:0] id_pc_plus4;
  logic                   id_valid;
  logic                   addr_fault;

  // Pipeline control, imem model and decode stage side.
  modport master (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, addr_fault
  );

  // Fetch unit side.
  modport slave (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, addr_fault
  );

endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC/fetch stage; BRANCH_DELAY_SLOT_EN keeps the slot after a redirect
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_unit_if.slave  bus
);

  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        addr_fault_q;

  logic [31:0] fetch_addr;
  logic        fetch_addr_bad;

  // Pick the address presented to imem: a plain stall re-reads the slot already in flight
  // so the registered imem output (and therefore id_*) stays put.
  always_comb begin
    fetch_addr     = (bus.stall && !bus.redirect) ? fetch_pc : pc;
    fetch_addr_bad = (fetch_addr[1:0] != 2'b00) || (word_index(fetch_addr) >= IMEM_WORDS);
    bus.imem_addr  = fetch_addr_bad ? '0 : word_index(fetch_addr);
  end

  // PC and fetch-slot state: rst > redirect > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      fetch_pc     <= RESET_PC;
      fetch_valid  <= 1'b0;
      addr_fault_q <= 1'b0;
    end else if (bus.redirect) begin
      pc       <= bus.redirect_pc;
      fetch_pc <= fetch_addr;
`ifdef BRANCH_DELAY_SLOT_EN
      fetch_valid <= !fetch_addr_bad;
      if (fetch_addr_bad) addr_fault_q <= 1'b1;
`else
      fetch_valid <= 1'b0;
`endif
    end else if (!bus.stall) begin
      pc          <= pc + 32'd4;
      fetch_pc    <= fetch_addr;
      fetch_valid <= !fetch_addr_bad;
      if (fetch_addr_bad) addr_fault_q <= 1'b1;
    end
  end

  // Decode-side view of the slot; invalid slots show a NOP.
  always_comb begin
    bus.id_instr    = fetch_valid ? bus.imem_instr : NOP_INSTR;
    bus.id_pc       = fetch_pc;
    bus.id_pc_plus4 = fetch_pc + 32'd4;
    bus.id_valid    = fetch_valid;
    bus.addr_fault  = addr_fault_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit with a behavioural fetch model
module tb_pc_fetch_unit;

  localparam int unsigned IMEM_WORDS = 64;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [IMEM_WORDS];
  always @(posedge clk) bus.imem_instr <= mem[bus.imem_addr[5:0]];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference: the next address to fetch, the slot currently shown to decode, sticky fault.
  logic [31:0] m_next;
  logic [31:0] m_slot_pc;
  logic        m_slot_ok;
  logic        m_fault;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= IMEM_WORDS);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_next    = RESET_PC;
    m_slot_pc = RESET_PC;
    m_slot_ok = 1'b0;
    m_fault   = 1'b0;
  endtask

  // One cycle: drive inputs, record what the DUT must show now, then step the model.
  task automatic cyc(input bit r, input bit st, input bit rd, input logic [31:0] rp);
    exp_t        e;
    logic [31:0] a;
    @(negedge clk);
    rst             = r;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rp;
    a       = (st && !rd) ? m_slot_pc : m_next;
    e.addr  = bad_addr(a) ? 32'd0 : a / 4;
    e.instr = m_slot_ok ? mem[m_slot_pc / 4] : 32'd0;
    e.pc    = m_slot_pc;
    e.pc4   = m_slot_pc + 4;
    e.valid = m_slot_ok;
    e.fault = m_fault;
    exp_q.push_back(e);
    if (r) begin
      model_reset();
    end else if (rd) begin
`ifdef BRANCH_DELAY_SLOT_EN
      m_slot_pc = m_next;
      m_slot_ok = !bad_addr(m_next);
      m_fault   = m_fault | bad_addr(m_next);
`else
      m_slot_pc = m_next;
      m_slot_ok = 1'b0;
`endif
      m_next = rp;
    end else if (!st) begin
      m_slot_pc = m_next;
      m_slot_ok = !bad_addr(m_next);
      m_fault   = m_fault | bad_addr(m_next);
      m_next    = m_next + 4;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0);
  endtask

  // Monitor: compare the outputs settled after each edge with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_addr",   bus.imem_addr,   e.addr);
        chk("id_instr",    bus.id_instr,    e.instr);
        chk("id_pc",       bus.id_pc,       e.pc);
        chk("id_pc_plus4", bus.id_pc_plus4, e.pc4);
        chk("id_valid",    {31'd0, bus.id_valid},   {31'd0, e.valid});
        chk("addr_fault",  {31'd0, bus.addr_fault}, {31'd0, e.fault});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rp;
    int          k;
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    @(posedge clk);
    model_reset();

    cyc(1, 0, 0, 32'd0);
    cyc(1, 1, 1, 32'h20);
    run(3);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'd0);
    run(2);
    cyc(0, 0, 1, 32'h40);
    run(3);
    cyc(0, 1, 1, 32'h80);
    run(2);
    cyc(0, 0, 1, 32'h42);
    run(2);
    cyc(0, 0, 1, IMEM_WORDS * 4);
    run(2);
    cyc(0, 1, 0, 32'd0);
    run(1);
    cyc(1, 1, 1, 32'h10);
    run(2);
    cyc(0, 0, 1, 32'hFFFF_FFF8);
    run(4);
    cyc(1, 0, 0, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(0, 7);
      case (k)
        0:       rp = {24'd0, 6'($urandom_range(0, 63)), 2'b10};
        1:       rp = IMEM_WORDS * 4 + 4 * $urandom_range(0, 15);
        2:       rp = 32'hFFFF_FFF8;
        default: rp = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      endcase
      cyc($urandom_range(0, 99) < 3, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, rp);
    end
    cyc(0, 0, 0, 32'd0);

    @(negedge clk);
    #5;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
